// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - PPU shared types, register addresses and VRAM address helpers
package ppu_pkg;

    // VMAIN fields that affect the VRAM port; bits 6:4 have no effect and are not stored
    typedef struct packed {
        logic       inc_high;
        logic [1:0] remap;
        logic [1:0] step;
    } vmain_type;

    localparam logic [7:0] REG_VMAIN       = 8'h15;
    localparam logic [7:0] REG_VMADDL      = 8'h16;
    localparam logic [7:0] REG_VMADDH      = 8'h17;
    localparam logic [7:0] REG_VMDATAL     = 8'h18;
    localparam logic [7:0] REG_VMDATAH     = 8'h19;
    localparam logic [7:0] REG_VMDATALREAD = 8'h39;
    localparam logic [7:0] REG_VMDATAHREAD = 8'h3A;

    typedef enum logic [1:0] {
        VP_IDLE    = 2'd0,
        VP_WRITE   = 2'd1,
        VP_PF_ADDR = 2'd2,
        VP_PF_CAP  = 2'd3
    } vram_port_state_type;

    // Bus-side address translation: rotates the low 8/9/10 bits left by three
    function automatic logic [14:0] vram_remap(input logic [14:0] addr, input logic [1:0] mode);
        logic [14:0] result;
        case (mode)
            2'd0:    result = addr;
            2'd1:    result = {addr[14:8], addr[4:0], addr[7:5]};
            2'd2:    result = {addr[14:9], addr[5:0], addr[8:6]};
            default: result = {addr[14:10], addr[6:0], addr[9:7]};
        endcase
        return result;
    endfunction

    // Word increment selected by VMAIN step; 11 aliases 10
    function automatic logic [14:0] vram_step(input logic [1:0] step);
        logic [14:0] result;
        case (step)
            2'd0:    result = 15'd1;
            2'd1:    result = 15'd32;
            default: result = 15'd128;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/vram_cpu_port.sv
// rtl/vram_cpu_port.sv - CPU VRAM port: VMAIN/VMADD/VMDATA writes and prefetch read latch
module vram_cpu_port
    import ppu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic [7:0]  cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rd_hit,
    input  logic        vram_blocked,
    input  logic [14:0] ppu_addr,
    output logic [14:0] ram_addr,
    output logic        ram_we,
    output logic [1:0]  ram_be,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata
);

    vram_port_state_type state;
    vram_port_state_type state_next;

    vmain_type   vmain;
    logic [14:0] vmadd;
    logic [15:0] latch;
    logic        inc_pending;

    logic        wr_go;
    logic        rd_go;
    logic        rd_lo_inc;
    logic        rd_hi_inc;
    logic [14:0] bus_addr;

    // Strobes are only honoured from IDLE; a write wins over a simultaneous read
    assign wr_go = cpu_wr && (state == VP_IDLE);
    assign rd_go = cpu_rd && !cpu_wr && (state == VP_IDLE);

    // A data read increments (and refetches) only on the byte selected by inc_high
    assign rd_lo_inc = (cpu_addr == REG_VMDATALREAD) && !vmain.inc_high;
    assign rd_hi_inc = (cpu_addr == REG_VMDATAHREAD) &&  vmain.inc_high;

    assign bus_addr = vram_remap(vmadd, vmain.remap);

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= VP_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_next = state;
        case (state)
            VP_IDLE: begin
                if (wr_go) begin
                    case (cpu_addr)
                        REG_VMADDL, REG_VMADDH:   state_next = VP_PF_ADDR;
                        REG_VMDATAL, REG_VMDATAH: state_next = VP_WRITE;
                        default:                  state_next = VP_IDLE;
                    endcase
                end else if (rd_go && (rd_lo_inc || rd_hi_inc)) begin
                    state_next = VP_PF_ADDR;
                end
            end
            VP_WRITE:   state_next = VP_IDLE;
            VP_PF_ADDR: state_next = VP_PF_CAP;
            VP_PF_CAP:  state_next = VP_IDLE;
            default:    state_next = VP_IDLE;
        endcase
    end

    // FSM outputs: the port drives the VRAM bus only in WRITE/PF_ADDR while not rendering
    always_comb begin
        ram_addr = ppu_addr;
        ram_we   = 1'b0;
        if (!vram_blocked) begin
            if (state == VP_WRITE || state == VP_PF_ADDR) begin
                ram_addr = bus_addr;
            end
            if (state == VP_WRITE) begin
                ram_we = 1'b1;
            end
        end
    end

    // VMAIN register and write-lane setup captured at the write strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vmain     <= '0;
            ram_be    <= 2'b00;
            ram_wdata <= 16'h0000;
        end else if (wr_go) begin
            case (cpu_addr)
                REG_VMAIN: begin
                    vmain.inc_high <= cpu_wdata[7];
                    vmain.remap    <= cpu_wdata[3:2];
                    vmain.step     <= cpu_wdata[1:0];
                end
                REG_VMDATAL: begin
                    ram_be    <= 2'b01;
                    ram_wdata <= {cpu_wdata, cpu_wdata};
                end
                REG_VMDATAH: begin
                    ram_be    <= 2'b10;
                    ram_wdata <= {cpu_wdata, cpu_wdata};
                end
                default: ;
            endcase
        end
    end

    // VMADD: byte loads from the CPU, step increment at the end of WRITE/PF_ADDR
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vmadd       <= 15'h0000;
            inc_pending <= 1'b0;
        end else if (wr_go) begin
            case (cpu_addr)
                REG_VMADDL: begin
                    vmadd[7:0]  <= cpu_wdata;
                    inc_pending <= 1'b0;
                end
                REG_VMADDH: begin
                    vmadd[14:8] <= cpu_wdata[6:0];
                    inc_pending <= 1'b0;
                end
                REG_VMDATAL: inc_pending <= !vmain.inc_high;
                REG_VMDATAH: inc_pending <=  vmain.inc_high;
                default: ;
            endcase
        end else if (rd_go) begin
            inc_pending <= rd_lo_inc || rd_hi_inc;
        end else if ((state == VP_WRITE || state == VP_PF_ADDR) && inc_pending) begin
            vmadd <= vmadd + vram_step(vmain.step);
        end
    end

    // Prefetch latch: captures the word that came back from the PF_ADDR access
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            latch <= 16'h0000;
        end else if (state == VP_PF_CAP) begin
            latch <= ram_rdata;
        end
    end

    // CPU read port: return the latch byte and flag whether the address hit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_rdata  <= 8'h00;
            cpu_rd_hit <= 1'b0;
        end else if (rd_go) begin
            case (cpu_addr)
                REG_VMDATALREAD: begin
                    cpu_rdata  <= latch[7:0];
                    cpu_rd_hit <= 1'b1;
                end
                REG_VMDATAHREAD: begin
                    cpu_rdata  <= latch[15:8];
                    cpu_rd_hit <= 1'b1;
                end
                default: cpu_rd_hit <= 1'b0;
            endcase
        end
    end

endmodule
